// File: rtl/random_checker.sv
// random_checker: receive-side checker for the 2-bit LFSR random stream.
// Syncs a local LFSR to the incoming stream, then flags and counts mismatches.
// Ports:
//   clk, rst (sync, active-low), valid, random[1:0], clr
//   locked, err (pulse), lost (pulse), err_cnt[ERR_W-1:0] (saturating)
module random_checker #(
   parameter int unsigned LFSR_W   = 8,
   parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(8'hB8),
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned LOSS_CNT = 4,
   parameter int unsigned ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [1:0]       random,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic             lost,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int FW = $clog2(LFSR_W + 1);
   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(LOSS_CNT + 1);

   localparam logic [FW-1:0] FILL_LAST = FW'(LFSR_W - 1);
   localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } state_t;

   function automatic logic [LFSR_W-1:0] step(
      input logic [LFSR_W-1:0] s
   );
      return {s[LFSR_W-2:0], ^(s & TAPS)};
   endfunction

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] shadow_q, shadow_d;
   logic [LFSR_W-1:0] pred_q, pred_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic [RW-1:0]     run_q, run_d;
   logic [MW-1:0]     miss_q, miss_d;
   logic              err_d, lost_d, locked_d;
   logic [ERR_W-1:0]  cnt_d;
   logic [LFSR_W-1:0] shadow_nx;
   logic              hit;

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      pred_d    = pred_q;
      fill_d    = fill_q;
      run_d     = run_q;
      miss_d    = miss_q;
      err_d     = 1'b0;
      lost_d    = 1'b0;
      cnt_d     = err_cnt;
      // the generator's s[0] becomes s[1] next step, so shifting in
      // random[0] rebuilds the full generator state after W samples
      shadow_nx = (shadow_q << 1) | LFSR_W'(random[0]);
      hit       = (random == pred_q[1:0]);

      if (valid) begin
         unique case (state_q)
            HUNT: begin
               shadow_d = shadow_nx;
               // random[1] must repeat the previous random[0]
               if (fill_q != '0 && random[1] != shadow_q[0]) begin
                  fill_d = FW'(1);
               end else if (fill_q == FILL_LAST) begin
                  fill_d = '0;
                  if (shadow_nx != '0) begin
                     state_d = VERIFY;
                     pred_d  = step(shadow_nx);
                     run_d   = '0;
                  end
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            VERIFY: begin
               pred_d = step(pred_q);
               if (hit) begin
                  if (run_q == RUN_LAST) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
               end else begin
                  state_d = HUNT;
                  fill_d  = '0;
               end
            end
            LOCKED: begin
               pred_d = step(pred_q);
               if (hit) begin
                  miss_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (!(&err_cnt)) cnt_d = err_cnt + 1'b1;
                  if (miss_q == MISS_LAST) begin
                     state_d = HUNT;
                     lost_d  = 1'b1;
                     fill_d  = '0;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      // a clear still counts a mismatch accepted on the same edge
      if (clr) cnt_d = ERR_W'(err_d);

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= HUNT;
         shadow_q <= '0;
         pred_q   <= '0;
         fill_q   <= '0;
         run_q    <= '0;
         miss_q   <= '0;
         locked   <= 1'b0;
         err      <= 1'b0;
         lost     <= 1'b0;
         err_cnt  <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         pred_q   <= pred_d;
         fill_q   <= fill_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         locked   <= locked_d;
         err      <= err_d;
         lost     <= lost_d;
         err_cnt  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_random_checker.sv
// tb_random_checker: directed table-driven bench for random_checker.
// Drives a seeded generator stream with per-step corruption masks.
module tb_random_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [1:0]  random = 2'b00;
   logic        clr = 1'b0;
   logic        locked, err, lost;
   logic [15:0] err_cnt;

   logic [7:0]  g = 8'h01;
   int          passed = 0;
   int          total = 0;

   typedef struct {
      string      nm;
      int         rep;
      bit         r;
      bit         v;
      bit         z;
      logic [1:0] xm;
      bit         c;
      bit         lk;
      bit         e;
      bit         ls;
      int         cnt;
   } vec_t;

   vec_t tbl[$];

   random_checker dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .random  (random),
      .clr     (clr),
      .locked  (locked),
      .err     (err),
      .lost    (lost),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gstep(input logic [7:0] s);
      return {s[6:0], ^(s & 8'hB8)};
   endfunction

   function automatic void add(
      input string nm, input int rep,
      input bit r, input bit v, input bit z,
      input logic [1:0] xm, input bit c,
      input bit lk, input bit e, input bit ls,
      input int cnt
   );
      vec_t t;
      t.nm = nm; t.rep = rep; t.r = r; t.v = v;
      t.z = z; t.xm = xm; t.c = c; t.lk = lk;
      t.e = e; t.ls = ls; t.cnt = cnt;
      tbl.push_back(t);
   endfunction

   task automatic drive(
      input bit r, input bit v, input bit z,
      input logic [1:0] xm, input bit c
   );
      @(negedge clk);
      rst   = r;
      valid = v;
      clr   = c;
      if (z) random = 2'b00;
      else if (v) random = g[1:0] ^ xm;
      else random = 2'(~g[1:0]);
      @(posedge clk);
      if (v && !z) g = gstep(g);
      #1;
   endtask

   task automatic chk(
      input string nm, input bit lk, input bit e,
      input bit ls, input int cnt
   );
      total++;
      if ({locked, err, lost} === {lk, e, ls} &&
          err_cnt === 16'(cnt)) begin
         passed++;
      end else begin
         $display("FAIL %s: got locked=%b err=%b lost=%b cnt=%0d, want %b %b %b %0d",
                  nm, locked, err, lost, err_cnt, lk, e, ls, cnt);
      end
   endtask

   initial begin
      //   name     rep rst v z  xm  clr lk e ls cnt
      add("rst",      2, 0, 1, 0, 2'b00, 1, 0, 0, 0, 0);
      add("hunt",    15, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      add("lock16",   1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 0);
      add("run200", 200, 1, 1, 0, 2'b00, 0, 1, 0, 0, 0);
      add("err1",     1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 1);
      add("post1",    5, 1, 1, 0, 2'b00, 0, 1, 0, 0, 1);
      add("bad2",     1, 1, 1, 0, 2'b10, 0, 1, 1, 0, 2);
      add("bad3",     1, 1, 1, 0, 2'b11, 0, 1, 1, 0, 3);
      add("bad4",     1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 4);
      add("lose",     1, 1, 1, 0, 2'b10, 0, 0, 1, 1, 5);
      add("relk",    15, 1, 1, 0, 2'b00, 0, 0, 0, 0, 5);
      add("relk16",   1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 5);
      add("clr",      1, 1, 1, 0, 2'b00, 1, 1, 0, 0, 0);
      add("m1",       1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 1);
      add("m2",       1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 2);
      add("m3",       1, 1, 1, 0, 2'b01, 0, 1, 1, 0, 3);
      add("mfix",     1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 3);
      add("m4",       1, 1, 1, 0, 2'b10, 0, 1, 1, 0, 4);
      add("m5",       1, 1, 1, 0, 2'b10, 0, 1, 1, 0, 5);
      add("m6",       1, 1, 1, 0, 2'b10, 0, 1, 1, 0, 6);
      add("mok",      1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 6);
      add("rstlk",    1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      add("vfy",     10, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      add("vbad",     1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0);
      add("vhunt",   15, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      add("vlock",    1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 0);
      add("rst2",     1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      add("zero",    50, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
      add("rst3",     1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);

      foreach (tbl[k]) begin
         for (int n = 0; n < tbl[k].rep; n++) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].z,
                  tbl[k].xm, tbl[k].c);
            chk(tbl[k].nm, tbl[k].lk, tbl[k].e,
                tbl[k].ls, tbl[k].cnt);
         end
      end

      // valid every other cycle: 16th sample lands on cycle 30
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, (i % 2) == 0, 1'b0, 2'b00, 1'b0);
         chk("toggle", i >= 30, 1'b0, 1'b0, 0);
      end

      drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
      chk("idle", 1'b1, 1'b0, 1'b0, 0);

      drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
      chk("clrerr", 1'b1, 1'b1, 1'b0, 1);

      drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
      chk("rstlk2", 1'b0, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
